axc_error_sweep_ctrl: RTL and testbench
=======================================

// Module: axc_error_sweep_ctrl
// PURPOSE
// Sequencer that exhaustively characterises one approximate circuit against its exact
// counterpart. It drives every input vector 0..2^IN_W-1 onto a shared stimulus bus
// that feeds both instances, and compares their outputs each cycle. It accumulates the
// worst-case error, the error sum, the count of erroneous vectors and the first
// threshold violation. Sits between the approximate circuit under evaluation and the
// host/testbench that accepts or rejects the candidate.
// PARAMETERS
// IN_W   4  circuit input width; sweep length is 2^IN_W vectors
// OUT_W  3  circuit output width; outputs are unsigned integers
// ET     2  error threshold; any |exact-approx| > ET is a violation
// PORTS
// clk            in   1              rising-edge clock
// rst_n          in   1              synchronous active-low reset
// start          in   1              one-cycle request to begin a sweep (IDLE only)
// vec            out  IN_W           stimulus to both exact and approx instances
// exact_out      in   OUT_W          exact circuit output for current vec (combinational)
// approx_out     in   OUT_W          approximate circuit output for current vec
// busy           out  1              high while sweeping
// done           out  1              one-cycle pulse when results are final
// max_err        out  OUT_W          max |exact-approx| over swept vectors
// sum_err        out  OUT_W+IN_W     sum of |exact-approx| over swept vectors
// err_cnt        out  IN_W+1         number of vectors with nonzero error
// violation      out  1              sticky: some vector exceeded ET
// first_viol_vec out  IN_W           vec of first violation (0 if none)
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): state=IDLE; vec, busy, done, max_err, sum_err,
//   err_cnt, violation and first_viol_vec all go to 0. Reset mid-sweep aborts the sweep
//   and raises no done.
// - FSM IDLE -> SWEEP on start. SWEEP -> DONE after the vector 2^IN_W-1 cycle.
//   DONE -> IDLE unconditionally after 1 cycle.
// - Edge where start is seen in IDLE: clear all accumulators, vec<=0, busy<=1.
// - start in SWEEP/DONE is ignored (no restart, no queueing).
// - SWEEP: vec is registered. exact_out/approx_out are sampled in the same cycle vec
//   is presented; the datapath has no pipeline stages.
// - Per cycle: d = |exact_out-approx_out|, computed in OUT_W+1 bits and fitting in
//   OUT_W bits. Updates: max_err<=max(max_err,d); sum_err+=d (cannot overflow);
//   err_cnt+=(d!=0).
// - Violation: if d>ET and violation==0, set violation and first_viol_vec<=vec.
//   Later violations keep first_viol_vec unchanged.
// - Sweep end: on vec==2^IN_W-1 the FSM goes to DONE and does not wrap. The vec
//   counter saturates and is then cleared to 0 on entry to IDLE.
// - DONE: busy=0, done=1 for exactly one cycle. Results hold until the next accepted
//   start or reset.
// - Timing (start seen at edge 0): vec=k during cycle k+1 for k=0..2^IN_W-1; busy=1 in
//   cycles 1..2^IN_W; done=1 in cycle 2^IN_W+1. The default sweep is 16 vectors with
//   done in cycle 17.
// - ET>=2^OUT_W-1 makes violation unreachable; this is legal.
// CONFIGURATION
// EARLY_ABORT_EN defined: the first violation ends the sweep. The FSM goes to DONE on
//   the next edge, so done comes one cycle after the violating vec.
//   max_err/sum_err/err_cnt then cover only vectors 0..first_viol_vec inclusive.
// EARLY_ABORT_EN undefined: the sweep always covers all 2^IN_W vectors. Violation
//   only flags the result.
// TESTING
// 1. approx_out==exact_out for all vec, start at cycle 0 -> done in cycle 17;
//    max_err=0, sum_err=0, err_cnt=0, violation=0, first_viol_vec=0.
// 2. approx=exact^3'b001 when vec is odd -> max_err=1, sum_err=8, err_cnt=8, violation=0.
// 3. approx=exact^3'b100 only at vec=5 (exact<4) -> max_err=4, sum_err=4, err_cnt=1,
//    violation=1, first_viol_vec=5. With EARLY_ABORT_EN: done in cycle 7, sum_err=4.
// 4. Errors d=3 at vec=9 and d=4 at vec=12 -> first_viol_vec=9, max_err=4, sum_err=7,
//    err_cnt=2.
// 5. rst_n=0 at cycle 8 of a sweep -> next cycle busy=0, all outputs 0, no done pulse.
//    A start after reset runs a full clean sweep.
// 6. start held high through the whole sweep and during the DONE cycle -> exactly one
//    sweep per start seen in IDLE. A second sweep starts only on start in IDLE (cycle 18).

Source files
------------

// File: rtl/axc_error_sweep_ctrl_if.sv
// rtl/axc_error_sweep_ctrl_if.sv - stimulus/response and result bus of the error sweep sequencer
interface axc_error_sweep_ctrl_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3
);
  logic                  start;
  logic [IN_W-1:0]       vec;
  logic [OUT_W-1:0]      exact_out;
  logic [OUT_W-1:0]      approx_out;
  logic                  busy;
  logic                  done;
  logic [OUT_W-1:0]      max_err;
  logic [OUT_W+IN_W-1:0] sum_err;
  logic [IN_W:0]         err_cnt;
  logic                  violation;
  logic [IN_W-1:0]       first_viol_vec;

  modport slave (
    input  start, exact_out, approx_out,
    output vec, busy, done, max_err, sum_err, err_cnt, violation, first_viol_vec
  );

  modport master (
    output start, exact_out, approx_out,
    input  vec, busy, done, max_err, sum_err, err_cnt, violation, first_viol_vec
  );
endinterface

// File: rtl/axc_error_sweep_ctrl.sv
// rtl/axc_error_sweep_ctrl.sv - exhaustive exact-vs-approximate error sweep sequencer
// Optional EARLY_ABORT_EN: the first threshold violation ends the sweep.
module axc_error_sweep_ctrl #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3,
  parameter int ET    = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  axc_error_sweep_ctrl_if.slave bus
);
  localparam logic [IN_W-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [IN_W-1:0]       vec_q, vec_d;
  logic [OUT_W-1:0]      max_err_q, max_err_d;
  logic [OUT_W+IN_W-1:0] sum_err_q, sum_err_d;
  logic [IN_W:0]         err_cnt_q, err_cnt_d;
  logic                  viol_q, viol_d;
  logic [IN_W-1:0]       first_viol_q, first_viol_d;

  logic [OUT_W:0]   diff_full;
  logic [OUT_W:0]   abs_full;
  logic [OUT_W-1:0] d;
  logic             new_viol;

  // Difference is taken one bit wider so the sign is visible before taking magnitude.
  always_comb begin
    diff_full = {1'b0, bus.exact_out} - {1'b0, bus.approx_out};
    abs_full  = diff_full[OUT_W] ? (~diff_full + 1'b1) : diff_full;
    d         = abs_full[OUT_W-1:0];
    new_viol  = (32'(abs_full) > 32'(ET)) && !viol_q;
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    max_err_d    = max_err_q;
    sum_err_d    = sum_err_q;
    err_cnt_d    = err_cnt_q;
    viol_d       = viol_q;
    first_viol_d = first_viol_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_SWEEP;
          vec_d        = '0;
          max_err_d    = '0;
          sum_err_d    = '0;
          err_cnt_d    = '0;
          viol_d       = 1'b0;
          first_viol_d = '0;
        end
      end
      S_SWEEP: begin
        if (d > max_err_q) max_err_d = d;
        sum_err_d = sum_err_q + (OUT_W+IN_W)'(d);
        err_cnt_d = err_cnt_q + (IN_W+1)'(d != '0);
        if (new_viol) begin
          viol_d       = 1'b1;
          first_viol_d = vec_q;
        end
`ifdef EARLY_ABORT_EN
        if (vec_q == LAST_VEC || new_viol) state_d = S_DONE;
        else                               vec_d   = vec_q + 1'b1;
`else
        if (vec_q == LAST_VEC) state_d = S_DONE;
        else                   vec_d   = vec_q + 1'b1;
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      max_err_q    <= '0;
      sum_err_q    <= '0;
      err_cnt_q    <= '0;
      viol_q       <= 1'b0;
      first_viol_q <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      max_err_q    <= max_err_d;
      sum_err_q    <= sum_err_d;
      err_cnt_q    <= err_cnt_d;
      viol_q       <= viol_d;
      first_viol_q <= first_viol_d;
    end
  end

  assign bus.vec            = vec_q;
  assign bus.busy           = (state_q == S_SWEEP);
  assign bus.done           = (state_q == S_DONE);
  assign bus.max_err        = max_err_q;
  assign bus.sum_err        = sum_err_q;
  assign bus.err_cnt        = err_cnt_q;
  assign bus.violation      = viol_q;
  assign bus.first_viol_vec = first_viol_q;
endmodule

// File: tb/tb_axc_error_sweep_ctrl.sv
// tb/tb_axc_error_sweep_ctrl.sv - directed-vector bench for axc_error_sweep_ctrl
module tb_axc_error_sweep_ctrl;
  logic clk;
  logic rst_n;
  int   mode;
  int   n_tests;
  int   n_fail;

  axc_error_sweep_ctrl_if #(.IN_W(4), .OUT_W(3)) bus ();

  axc_error_sweep_ctrl #(.IN_W(4), .OUT_W(3), .ET(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact circuit: low two bits of vec. Approx circuit selected by mode.
  always_comb begin
    bus.exact_out  = {1'b0, bus.vec[1:0]};
    bus.approx_out = bus.exact_out;
    case (mode)
      1: if (bus.vec[0]) bus.approx_out = bus.exact_out ^ 3'b001;
      2: if (bus.vec == 4'd5) bus.approx_out = bus.exact_out ^ 3'b100;
      3: begin
        if (bus.vec == 4'd9)  bus.approx_out = 3'd4;
        if (bus.vec == 4'd12) bus.approx_out = 3'd4;
      end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int done_cyc;
  int done_cnt;
  int done2_cyc;
  logic [3:0] vec_c1;
  logic [3:0] vec_c16;
  logic busy_c18;
  logic busy_c19;

  // Pulse (or hold) start so the accepting edge is edge 0, then observe ncyc cycles.
  task automatic run_sweep(input int m, input bit hold, input int ncyc);
    mode      = m;
    done_cyc  = 0;
    done2_cyc = 0;
    done_cnt  = 0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 if (!hold) bus.start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
        else if (done2_cyc == 0) done2_cyc = c;
      end
      if (c == 1)  vec_c1   = bus.vec;
      if (c == 16) vec_c16  = bus.vec;
      if (c == 18) busy_c18 = bus.busy;
      if (c == 19) busy_c19 = bus.busy;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_results(input string t, input int mx, input int sm, input int cnt,
                               input int v, input int fv);
    check_eq({t, " max_err"}, 32'(bus.max_err), 32'(mx));
    check_eq({t, " sum_err"}, 32'(bus.sum_err), 32'(sm));
    check_eq({t, " err_cnt"}, 32'(bus.err_cnt), 32'(cnt));
    check_eq({t, " violation"}, 32'(bus.violation), 32'(v));
    check_eq({t, " first_viol_vec"}, 32'(bus.first_viol_vec), 32'(fv));
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    mode      = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst busy", 32'(bus.busy), 0);
    check_eq("rst done", 32'(bus.done), 0);
    check_eq("rst vec", 32'(bus.vec), 0);
    check_results("rst", 0, 0, 0, 0, 0);

    run_sweep(0, 1'b0, 20);
    check_eq("t1 done_cyc", 32'(done_cyc), 17);
    check_eq("t1 done_cnt", 32'(done_cnt), 1);
    check_eq("t1 vec c1", 32'(vec_c1), 0);
    check_eq("t1 vec c16", 32'(vec_c16), 15);
    check_eq("t1 vec idle", 32'(bus.vec), 0);
    check_results("t1", 0, 0, 0, 0, 0);

    run_sweep(1, 1'b0, 20);
    check_eq("t2 done_cyc", 32'(done_cyc), 17);
    check_results("t2", 1, 8, 8, 0, 0);

    run_sweep(2, 1'b0, 20);
`ifdef EARLY_ABORT_EN
    check_eq("t3 done_cyc", 32'(done_cyc), 7);
`else
    check_eq("t3 done_cyc", 32'(done_cyc), 17);
`endif
    check_results("t3", 4, 4, 1, 1, 5);

    run_sweep(3, 1'b0, 20);
`ifdef EARLY_ABORT_EN
    check_eq("t4 done_cyc", 32'(done_cyc), 11);
    check_results("t4", 3, 3, 1, 1, 9);
`else
    check_eq("t4 done_cyc", 32'(done_cyc), 17);
    check_results("t4", 4, 7, 2, 1, 9);
`endif

    mode = 3;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (7) @(negedge clk);
    @(negedge clk);
    check_eq("t5 busy c8", 32'(bus.busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("t5 busy after rst", 32'(bus.busy), 0);
    check_eq("t5 vec after rst", 32'(bus.vec), 0);
    check_results("t5 rst", 0, 0, 0, 0, 0);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check_eq("t5 no done", 32'(done_cnt), 0);
    run_sweep(1, 1'b0, 20);
    check_eq("t5 rerun done_cyc", 32'(done_cyc), 17);
    check_results("t5 rerun", 1, 8, 8, 0, 0);

    run_sweep(0, 1'b1, 36);
    check_eq("t6 done_cyc", 32'(done_cyc), 17);
    check_eq("t6 busy c18", 32'(busy_c18), 0);
    check_eq("t6 busy c19", 32'(busy_c19), 1);
    check_eq("t6 done2_cyc", 32'(done2_cyc), 35);
    check_eq("t6 done_cnt", 32'(done_cnt), 2);
    repeat (24) @(negedge clk);
    check_eq("t6 idle busy", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
